// File: rtl/bram_pingpong_if.sv
// Ping-pong controller bus: job control, BRAM port A/B controls, external memory
// address and the read-stream handshake toward the consumer.
interface bram_pingpong_if;
    logic        start;
    logic [8:0]  num_frames;
    logic        busy;
    logic        complete;
    logic [17:0] mem_address;
    logic        EN_A;
    logic        W_A;
    logic [10:0] ADDR_A;
    logic        EN_B;
    logic [8:0]  ADDR_B;
    logic        rd_ready;
    logic        rd_valid;
    logic        rd_last;
    logic [1:0]  bank_full;

    modport master (
        input  start, num_frames, rd_ready,
        output busy, complete, mem_address, EN_A, W_A, ADDR_A,
               EN_B, ADDR_B, rd_valid, rd_last, bank_full
    );

    modport slave (
        output start, num_frames, rd_ready,
        input  busy, complete, mem_address, EN_A, W_A, ADDR_A,
               EN_B, ADDR_B, rd_valid, rd_last, bank_full
    );
endinterface

// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong scheduler for a dual-port BRAM: port A fills one 1 KB bank from external
// memory while port B drains the other as 32-bit words, with full/empty bank tracking.
module bram_pingpong_ctrl (
    input  logic            CLK,
    input  logic            rst,
    bram_pingpong_if.master bus
);
    localparam int unsigned FRAME_W = 9;
    localparam int unsigned BYTE_W  = 10;
    localparam int unsigned WORD_W  = 8;

    typedef enum logic [1:0] {IDLE,   RUN,    DONE}    top_e;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT}  wr_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRAIN} rd_e;

    top_e                top_q,     top_d;
    wr_e                 wst_q,     wst_d;
    rd_e                 rdst_q,    rdst_d;
    logic                wb_q,      wb_d;
    logic                rb_q,      rb_d;
    logic [BYTE_W-1:0]   woff_q,    woff_d;
    logic [WORD_W-1:0]   roff_q,    roff_d;
    logic [FRAME_W-1:0]  wframe_q,  wframe_d;
    logic [FRAME_W-1:0]  rframe_q,  rframe_d;
    logic [FRAME_W-1:0]  nframes_q, nframes_d;
    logic [1:0]          full_q,    full_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q,  rd_last_d;

    logic fill_c;
    logic issue_c;
    logic wr_end_c;
    logic rd_end_c;

    always_comb begin
        top_d      = top_q;
        wst_d      = wst_q;
        rdst_d     = rdst_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        woff_d     = woff_q;
        roff_d     = roff_q;
        wframe_d   = wframe_q;
        rframe_d   = rframe_q;
        nframes_d  = nframes_q;
        full_d     = full_q;

        fill_c     = (wst_q == W_FILL);
        issue_c    = (rdst_q inside {R_WAIT, R_DRAIN}) && full_q[rb_q] && bus.rd_ready;
        wr_end_c   = fill_c && (woff_q == '1);
        rd_end_c   = issue_c && (roff_q == '1);
        rd_valid_d = issue_c;
        rd_last_d  = rd_end_c;

        // Flags settle first so both FSMs decide on post-edge occupancy (no bubble on free banks)
        if (wr_end_c) full_d[wb_q] = 1'b1;
        if (rd_end_c) full_d[rb_q] = 1'b0;

        unique case (wst_q)
            W_FILL: begin
                woff_d = woff_q + BYTE_W'(1);
                if (wr_end_c) begin
                    wb_d     = ~wb_q;
                    wframe_d = wframe_q + FRAME_W'(1);
                    if (wframe_d == nframes_q) begin
                        wst_d = W_IDLE;
                    end else if (full_d[wb_d]) begin
                        wst_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (!full_d[wb_q]) wst_d = W_FILL;
            end
            default: ;
        endcase

        unique case (rdst_q)
            R_WAIT, R_DRAIN: begin
                if (issue_c) begin
                    roff_d = roff_q + WORD_W'(1);
                    rdst_d = R_DRAIN;
                    if (rd_end_c) begin
                        rb_d     = ~rb_q;
                        rframe_d = rframe_q + FRAME_W'(1);
                        if (rframe_d == nframes_q) begin
                            rdst_d = R_IDLE;
                        end else begin
                            rdst_d = R_WAIT;
                        end
                    end
                end
            end
            default: ;
        endcase

        unique case (top_q)
            IDLE: begin
                if (bus.start) begin
                    nframes_d = bus.num_frames;
                    wb_d      = 1'b0;
                    rb_d      = 1'b0;
                    woff_d    = '0;
                    roff_d    = '0;
                    wframe_d  = '0;
                    rframe_d  = '0;
                    full_d    = '0;
                    if (bus.num_frames == '0) begin
                        top_d = DONE;
                    end else begin
                        top_d  = RUN;
                        wst_d  = W_FILL;
                        rdst_d = R_WAIT;
                    end
                end
            end
            RUN: begin
                // Job ends once the final word of the final frame has been presented
                if (rd_valid_q && rd_last_q && (rframe_q == nframes_q)) top_d = DONE;
            end
            DONE:    top_d = IDLE;
            default: top_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            top_q      <= IDLE;
            wst_q      <= W_IDLE;
            rdst_q     <= R_IDLE;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            woff_q     <= '0;
            roff_q     <= '0;
            wframe_q   <= '0;
            rframe_q   <= '0;
            nframes_q  <= '0;
            full_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            top_q      <= top_d;
            wst_q      <= wst_d;
            rdst_q     <= rdst_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            woff_q     <= woff_d;
            roff_q     <= roff_d;
            wframe_q   <= wframe_d;
            rframe_q   <= rframe_d;
            nframes_q  <= nframes_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Addresses are forced to zero outside a fill so mem_address never runs past the job
    assign bus.busy        = (top_q == RUN);
    assign bus.complete    = (top_q == DONE);
    assign bus.EN_A        = fill_c;
    assign bus.W_A         = fill_c;
    assign bus.ADDR_A      = fill_c ? {wb_q, woff_q} : '0;
    assign bus.mem_address = fill_c ? {wframe_q[WORD_W-1:0], woff_q} : '0;
    assign bus.EN_B        = issue_c;
    assign bus.ADDR_B      = {rb_q, roff_q};
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.bank_full   = full_q;
endmodule

// File: doc/bram_pingpong_ctrl.md
# bram_pingpong_ctrl

Ping-pong scheduler for the true dual-port BRAM18 on the external-memory-to-steer datapath. The 2 KB BRAM is split into two 1 KB banks. Port A fills one bank with bytes streamed from the external memory while port B drains the other as 32-bit words toward the steer module. The block owns all BRAM enables and addresses plus the external memory address, and replaces free-running fill/read sequencing with full/empty bank tracking and consumer backpressure.

## Interface
- Parameters: none. Geometry is fixed: bank = 1024 bytes = 256 words; ADDR_A = {bank, 10-bit byte offset}; ADDR_B = {bank, 8-bit word offset}.
- CLK  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse; sampled only in IDLE.
- num_frames  in  9  number of 1 KB frames to move (0..256); latched on accepted start.
- busy  out  1  high from accepted start until complete.
- complete  out  1  one-cycle pulse at end of job.
- mem_address  out  18  external memory byte address (memory is combinational: data valid same cycle).
- EN_A  out  1  BRAM port A enable.
- W_A  out  1  BRAM port A write enable; always equal to EN_A.
- ADDR_A  out  11  BRAM port A byte address.
- EN_B  out  1  BRAM port B read enable.
- ADDR_B  out  9  BRAM port B word address.
- rd_ready  in  1  consumer permits a read issue this cycle.
- rd_valid  out  1  DOUT_B valid this cycle (EN_B delayed one cycle).
- rd_last  out  1  with rd_valid: last word of a frame.
- bank_full  out  2  registered full flag per bank.

## Operation
- Top FSM: IDLE -> RUN on start (start while RUN/DONE ignored) -> DONE when all frames written and last rd_valid emitted -> IDLE. complete is asserted in DONE for one cycle.
- num_frames == 0: IDLE -> DONE directly; complete pulses the cycle after start, with no EN_A or EN_B.
- Writer FSM W_IDLE/W_FILL/W_WAIT, bank pointer wb (reset 0):
  - In W_FILL: EN_A = W_A = 1, ADDR_A = {wb, woff}, mem_address = wframe*1024 + woff.
  - woff increments every cycle. At woff == 1023: set bank_full[wb], toggle wb, increment wframe.
  - If more frames remain, go to W_FILL if bank_full[next wb] == 0, else W_WAIT. W_WAIT exits to W_FILL the cycle after that flag reads 0.
- Reader FSM R_IDLE/R_WAIT/R_DRAIN, bank pointer rb (reset 0):
  - EN_B = (state in R_WAIT or R_DRAIN) & bank_full[rb] & rd_ready. ADDR_B = {rb, roff}.
  - roff increments on each issue. The issue at roff == 255 clears bank_full[rb], toggles rb and increments rframe.
- Byte packing is a BRAM property: word k holds bytes 4k..4k+3, with byte 4k in bits [7:0].
- The writer and reader never address the same bank in the same cycle, so a simultaneous set and clear of one flag cannot occur. A bank cleared on edge E is writable from cycle E+1.
- rd_ready low stalls issue only. A read already issued always returns rd_valid the next cycle; the consumer must accept it.
- Reset mid-operation: all FSMs to idle, counters, pointers and flags to 0, the in-flight read is discarded (rd_valid 0).
- Reset values: all outputs 0.

## Timing
- Accepted start at cycle 0 -> first EN_A at cycle 1 with ADDR_A = 0, mem_address = 0.
- One frame fill takes 1024 cycles. Consecutive bank fills have no bubble when the next bank is empty.
- bank_full is set on the edge ending the last write cycle. The earliest EN_B for that bank is the following cycle.
- Read latency: rd_valid = EN_B of the previous cycle. rd_last accompanies the word read at roff 255.
- complete pulses the cycle after the final rd_valid.
- mem_address never exceeds num_frames*1024 - 1. At 256 frames the wframe count wraps mem_address to 0 but the writer stops.

## Test plan
- Reset: hold rst = 0 three cycles with start = 1 -> all outputs 0, busy 0, no BRAM enables.
- 1 frame, rd_ready = 1: start at cycle 0 -> EN_A cycles 1..1024; bank_full = 2'b01 at 1025; EN_B 1025..1280 with ADDR_B 0..255; rd_valid 1026..1281; rd_last at 1281; complete at 1282; data word 0 = {mem[3], mem[2], mem[1], mem[0]}.
- 2 frames, rd_ready = 1: second fill 1025..2048 at ADDR_A 1024..2047, mem_address 1024..2047; second drain EN_B 2049..2304 with ADDR_B 256..511; complete at 2306.
- 3 frames, rd_ready = 0 until cycle 3000: writer fills banks 0 and 1, then EN_A = 0 from 2049, bank_full = 2'b11. EN_B 3000..3255. Writer resumes at 3256 with ADDR_A = 0, mem_address = 2048.
- rd_ready toggled every cycle: EN_B only on ready cycles; rd_valid count = 256 per frame; no bank overwritten before drained (scoreboard vs E_MEM).
- Edge cases: num_frames = 0 -> complete at cycle 1. start during RUN -> ignored. rst low at cycle 1100 -> all outputs 0 next cycle; a fresh start after reset runs 1 frame correctly.
